// File: rtl/vga_timing_if.sv
// Video timing bus between the timing generator (out) and the draw stage (in).
interface vga_if #(
  parameter int CNT_W = 11
);
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hblnk;
  logic             vblnk;
  logic             hsync;
  logic             vsync;

  modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
  modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA timing generator: counters, blanking, sync and frame_start strobe.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic SYNC_POL = 1'b1,
  parameter int   CNT_W    = 11
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.out          vga_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2**CNT_W) begin : g_h_total_chk
    $error("vga_timing: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > 2**CNT_W) begin : g_v_total_chk
    $error("vga_timing: V_TOTAL does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

  // Window bounds carry one extra bit so an end bound equal to 2**CNT_W stays exact.
  localparam logic [CNT_W:0] H_BLNK_S = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SYNC_S = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SYNC_E = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_BLNK_S = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SYNC_S = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SYNC_E = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, v_q, h_nxt, v_nxt;
  logic             hblnk_q, vblnk_q, hsync_q, vsync_q;
  logic             hblnk_d, vblnk_d, hsync_d, vsync_d;
  logic             h_wrap, v_wrap, frame_d;

  // Flags are decoded from the next counter values so they register alongside them.
  always_comb begin
    h_wrap  = (h_q == H_LAST);
    v_wrap  = h_wrap && (v_q == V_LAST);
    h_nxt   = h_wrap ? '0 : h_q + CNT_ONE;
    v_nxt   = v_q;
    if (h_wrap) begin
      v_nxt = (v_q == V_LAST) ? '0 : v_q + CNT_ONE;
    end
    hblnk_d = ({1'b0, h_nxt} >= H_BLNK_S);
    vblnk_d = ({1'b0, v_nxt} >= V_BLNK_S);
    hsync_d = (({1'b0, h_nxt} >= H_SYNC_S) && ({1'b0, h_nxt} < H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (({1'b0, v_nxt} >= V_SYNC_S) && ({1'b0, v_nxt} < V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
    frame_d = v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      h_q         <= h_nxt;
      v_q         <= v_nxt;
      hblnk_q     <= hblnk_d;
      vblnk_q     <= vblnk_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      frame_start <= frame_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'h0000;
    end else if (frame_d) begin
      frame_cnt <= frame_cnt + 16'h0001;
    end
  end
`endif

  assign vga_out.hcount = h_q;
  assign vga_out.vcount = v_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing using a reduced raster so whole frames fit in a short run.
module tb_vga_timing;

  localparam int   HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int   VA = 10, VF = 1, VS = 2, VB = 2;
  localparam int   W  = 6;
  localparam logic SP = 1'b0;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FR = HT * VT;
  localparam int   EW = 2 * W + 21;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [15:0] act_cnt;

  vga_if #(.CNT_W(W)) bus ();

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  assign act_cnt = frame_cnt;
`else
  assign act_cnt = 16'h0000;
`endif

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP), .CNT_W(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_out    (bus),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .frame_start(frame_start)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_fs = 0;
  int got_fs = 0;
  bit drv_done = 0;

  // Reference: t = cycles since reset release; the raster position is just t mod line/frame.
  function automatic logic [EW-1:0] model(input int t);
    int h, v, c;
    logic hb, vb, hs, vs, fs;
    h  = t % HT;
    v  = (t / HT) % VT;
    hb = (h >= HA);
    vb = (v >= VA);
    hs = (h >= HA + HF && h < HA + HF + HS) ? SP : ~SP;
    vs = (v >= VA + VF && v < VA + VF + VS) ? SP : ~SP;
    fs = (t > 0) && (t % FR == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    c  = (t / FR) % 65536;
`else
    c  = 0;
`endif
    return {W'(h), W'(v), hb, vb, hs, vs, fs, 16'(c)};
  endfunction

  // driver: one push per clock edge describing what the DUT presents after it
  task automatic run_cycles(input int n, input int rst_odds, inout int t, inout int rst_left);
    logic [EW-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) t = 0;
      else     t = t + 1;
      e = model(t);
      if (e[16]) exp_fs++;
      exp_q.push_back(e);
      #1;
      if (rst_left > 0) rst_left = rst_left - 1;
      else if (rst_odds > 0 && $urandom_range(0, rst_odds - 1) == 0)
        rst_left = $urandom_range(1, 3);
      rst = (rst_left > 0);
    end
  endtask

  initial begin
    int t;
    int rst_left;
    t        = 0;
    rst_left = 3;
    rst      = 1'b1;
    run_cycles(1, 0, t, rst_left);
    run_cycles(1, 0, t, rst_left);
    run_cycles(1, 0, t, rst_left);
    // long reset-free stretch spanning several frame wraps
    run_cycles(3 * FR + 50, 0, t, rst_left);
    // random mid-frame resets
    run_cycles(2500, 300, t, rst_left);
    // guarantee a reset-free tail crossing another wrap
    rst_left = 0;
    rst = 1'b0;
    run_cycles(FR + 20, 0, t, rst_left);
    drv_done = 1;
  end

  // monitor: compare every presented cycle against the oldest expectation
  initial begin
    logic [EW-1:0] a, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.hcount, bus.vcount, bus.hblnk, bus.vblnk, bus.hsync, bus.vsync,
             frame_start, act_cnt};
        if (frame_start === 1'b1) got_fs++;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out_check @%0t: got h=%0d v=%0d hb/vb/hs/vs/fs=%b cnt=%0d, expected h=%0d v=%0d hb/vb/hs/vs/fs=%b cnt=%0d",
                   $time, a[EW-1 -: W], a[EW-1-W -: W], a[20:16], a[15:0],
                   e[EW-1 -: W], e[EW-1-W -: W], e[20:16], e[15:0]);
        end
      end
    end
  end

  // final report
  initial begin
    wait (drv_done);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    checks++;
    if (got_fs != exp_fs || exp_fs < 3) begin
      errors++;
      $display("FAIL frame_start_count: got %0d, expected %0d (at least 3)", got_fs, exp_fs);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
